// File: rtl/axi_interface_pkg.sv
// axi_interface_pkg: shared AXI widths, burst encodings and write responder state
package axi_interface_pkg;
    localparam int AXI_ADDR_SIZE = 32;
    localparam int AXI_DATA_SIZE = 4;
    localparam int AXI_MAX_SIZE = $clog2(AXI_DATA_SIZE);
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} axi_burst_t;
    typedef enum logic [2:0] {
        BYTE = 3'd0, HALFWORD = 3'd1, WORD = 3'd2, DWORD = 3'd3,
        BYTES_16 = 3'd4, BYTES_32 = 3'd5, BYTES_64 = 3'd6, BYTES_128 = 3'd7
    } axi_burst_size_t;
    typedef enum logic [1:0] {IDLE, DATA, RESP} axi_wr_state_t;
endpackage

// File: rtl/axi_write_interface.sv
// axi_write_interface: AXI4 write address, data and response channels without IDs
interface axi_write_interface;
    import axi_interface_pkg::*;
    logic [AXI_ADDR_SIZE-1:0]   AWADDR;
    logic [7:0]                 AWLEN;
    axi_burst_size_t            AWSIZE;
    axi_burst_t                 AWBURST;
    logic                       AWVALID;
    logic                       AWREADY;
    logic [AXI_DATA_SIZE*8-1:0] WDATA;
    logic [AXI_DATA_SIZE-1:0]   WSTRB;
    logic                       WLAST;
    logic                       WVALID;
    logic                       WREADY;
    logic                       BVALID;
    logic                       BREADY;
    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BVALID
    );
    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BVALID
    );
endinterface

// File: rtl/axi_burst_address_gen.sv
// axi_burst_address_gen: next beat address for FIXED, INCR and WRAP bursts
module axi_burst_address_gen
    import axi_interface_pkg::*;
(
    input  logic [AXI_ADDR_SIZE-1:0] addr,
    input  logic [AXI_ADDR_SIZE-1:0] start,
    input  axi_burst_size_t          size,
    input  logic [7:0]               len,
    input  axi_burst_t               burst,
    output logic [AXI_ADDR_SIZE-1:0] next_addr
);
    logic [AXI_ADDR_SIZE-1:0] bytes, incr, container, lower;
    assign bytes = AXI_ADDR_SIZE'(1) << size;
    assign incr = (addr & ~(bytes - 1'b1)) + bytes;
    // wrap lengths are restricted to 2/4/8/16 beats, so the container is a power of two
    assign container = bytes * (AXI_ADDR_SIZE'(len) + 1'b1);
    assign lower = start & ~(container - 1'b1);
    assign next_addr = burst == FIXED ? addr
                     : burst == WRAP && incr == lower + container ? lower
                     : incr;
endmodule

// File: rtl/axi_write_responder.sv
// axi_write_responder: AXI4 write slave that splits bursts into single-beat local writes
module axi_write_responder
    import axi_interface_pkg::*;
(
    input  logic                       ACLK,
    input  logic                       ARESET,
    axi_write_interface.slave          axi,
    output logic                       write_o,
    output logic [AXI_ADDR_SIZE-1:0]   write_address_o,
    output logic [AXI_DATA_SIZE*8-1:0] write_data_o,
    output logic [AXI_DATA_SIZE-1:0]   write_strobe_o,
    input  logic                       write_ready_i,
    output logic                       protocol_error_o
);
    axi_wr_state_t            state;
    axi_burst_size_t          size;
    axi_burst_t               burst;
    logic [AXI_ADDR_SIZE-1:0] addr, start, next_addr;
    logic [7:0]               len, cnt;
    logic                     aw_hs, beat, size_err, len_err;
    assign aw_hs = axi.AWVALID && axi.AWREADY;
    assign beat = axi.WVALID && axi.WREADY;
    assign size_err = int'(axi.AWSIZE) > AXI_MAX_SIZE;
    assign len_err = axi.AWBURST == WRAP && !(axi.AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15});
    assign axi.AWREADY = state == IDLE;
    assign axi.WREADY = state == DATA && write_ready_i;
    assign axi.BVALID = state == RESP;
    assign write_o = beat;
    assign write_address_o = addr;
    assign write_data_o = axi.WDATA;
    assign write_strobe_o = axi.WSTRB;
    // the beat counter, not WLAST, decides where the burst ends
    assign protocol_error_o = (aw_hs && (size_err || len_err))
                           || (beat && (axi.WLAST != (cnt == len)));
    axi_burst_address_gen u_addr_gen (
        .addr      (addr),
        .start     (start),
        .size      (size),
        .len       (len),
        .burst     (burst),
        .next_addr (next_addr)
    );
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
            addr  <= '0;
            start <= '0;
            len   <= '0;
            cnt   <= '0;
            size  <= BYTE;
            burst <= FIXED;
        end else begin
            case (state)
                IDLE: if (axi.AWVALID) begin
                    addr  <= axi.AWADDR;
                    start <= axi.AWADDR;
                    len   <= axi.AWLEN;
                    cnt   <= '0;
                    size  <= size_err ? axi_burst_size_t'(AXI_MAX_SIZE) : axi.AWSIZE;
                    burst <= len_err ? INCR : axi.AWBURST;
                    state <= DATA;
                end
                DATA: if (beat) begin
                    addr <= next_addr;
                    cnt  <= cnt + 1'b1;
                    if (cnt == len) state <= RESP;
                end
                RESP: if (axi.BREADY) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_write_responder.sv
// tb_axi_write_responder: randomized bursts checked against an address-list model
module tb_axi_write_responder;
    import axi_interface_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_en, write_ready, perr;
    logic [31:0] write_addr, write_data;
    logic [3:0]  write_strobe;
    int          n_checks = 0;
    int          n_fail = 0;

    axi_write_interface axi ();

    axi_write_responder dut (
        .ACLK             (clk),
        .ARESET           (rst),
        .axi              (axi),
        .write_o          (write_en),
        .write_address_o  (write_addr),
        .write_data_o     (write_data),
        .write_strobe_o   (write_strobe),
        .write_ready_i    (write_ready),
        .protocol_error_o (perr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_burst(input int bt, input int len, input int sz, input logic [31:0] a,
                             input int rdy_pct, input int err_beat, input int bstall);
        logic [31:0] bytes, aligned, container, lower, ea;
        bit          wrap_ok, aw_err, rdy, vld, last, br;
        int          i, cyc, k;
        wrap_ok   = bt == 2 && len inside {1, 3, 7, 15};
        aw_err    = sz > 2 || (bt == 2 && !wrap_ok);
        bytes     = 32'd1 << (sz > 2 ? 2 : sz);
        aligned   = a - (a % bytes);
        container = bytes * (len + 1);
        lower     = a - (a % container);
        @(negedge clk);
        axi.AWVALID = 1'b1;
        axi.AWADDR  = a;
        axi.AWLEN   = 8'(len);
        axi.AWSIZE  = axi_burst_size_t'(3'(sz));
        axi.AWBURST = axi_burst_t'(2'(bt));
        axi.WVALID  = 1'b1;
        write_ready = 1'b1;
        #1;
        check("aw_awready", axi.AWREADY, 1);
        check("aw_wready", axi.WREADY, 0);
        check("aw_write", write_en, 0);
        check("aw_bvalid", axi.BVALID, 0);
        check("aw_perr", perr, aw_err);
        i = 0;
        cyc = 0;
        while (i <= len && cyc < 400) begin
            @(negedge clk);
            axi.AWVALID = 1'b0;
            rdy  = $urandom_range(99) < rdy_pct;
            vld  = $urandom_range(99) < rdy_pct;
            last = (i == len) ^ (i == err_beat);
            write_ready = rdy;
            axi.WVALID  = vld;
            axi.WLAST   = last;
            axi.WDATA   = $urandom;
            axi.WSTRB   = 4'($urandom);
            #1;
            check("d_wready", axi.WREADY, rdy);
            check("d_write", write_en, rdy && vld);
            check("d_awready", axi.AWREADY, 0);
            check("d_bvalid", axi.BVALID, 0);
            check("d_perr", perr, rdy && vld && (last != (i == len)));
            if (rdy && vld) begin
                if (bt == 0 || i == 0) ea = a;
                else if (wrap_ok) ea = lower + ((aligned - lower + i * bytes) % container);
                else ea = aligned + i * bytes;
                check("d_addr", write_addr, ea);
                check("d_data", write_data, axi.WDATA);
                check("d_strobe", write_strobe, axi.WSTRB);
                i++;
            end
            cyc++;
        end
        check("beats_done", i, len + 1);
        k = 0;
        do begin
            @(negedge clk);
            br = k >= bstall;
            axi.BREADY  = br;
            axi.WVALID  = 1'b1;
            write_ready = 1'b1;
            #1;
            check("r_bvalid", axi.BVALID, 1);
            check("r_awready", axi.AWREADY, 0);
            check("r_wready", axi.WREADY, 0);
            check("r_write", write_en, 0);
            check("r_perr", perr, 0);
            k++;
        end while (!br);
    endtask

    task automatic reset_mid_burst();
        @(negedge clk);
        axi.AWVALID = 1'b1;
        axi.AWADDR  = 32'h200;
        axi.AWLEN   = 8'd7;
        axi.AWSIZE  = WORD;
        axi.AWBURST = INCR;
        axi.WVALID  = 1'b0;
        #1;
        check("rm_awready", axi.AWREADY, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            axi.AWVALID = 1'b0;
            axi.WVALID  = 1'b1;
            axi.WLAST   = 1'b0;
            write_ready = 1'b1;
            #1;
            check("rm_write", write_en, 1);
            check("rm_addr", write_addr, 32'h200 + 4 * i);
        end
        #1 rst = 1'b1;
        #1;
        check("rm_wready", axi.WREADY, 0);
        check("rm_write_rst", write_en, 0);
        check("rm_bvalid", axi.BVALID, 0);
        check("rm_awready_rst", axi.AWREADY, 1);
        check("rm_perr", perr, 0);
        @(negedge clk);
        rst = 1'b0;
        axi.WVALID = 1'b0;
    endtask

    initial begin
        int bt, len;
        axi.AWVALID = 1'b0;
        axi.AWADDR  = '0;
        axi.AWLEN   = '0;
        axi.AWSIZE  = WORD;
        axi.AWBURST = INCR;
        axi.WVALID  = 1'b0;
        axi.WDATA   = '0;
        axi.WSTRB   = '0;
        axi.WLAST   = 1'b0;
        axi.BREADY  = 1'b1;
        write_ready = 1'b1;
        repeat (3) @(negedge clk);
        axi.WVALID = 1'b1;
        #1;
        check("rst_awready", axi.AWREADY, 1);
        check("rst_wready", axi.WREADY, 0);
        check("rst_bvalid", axi.BVALID, 0);
        check("rst_write", write_en, 0);
        check("rst_perr", perr, 0);
        @(negedge clk);
        rst = 1'b0;
        axi.WVALID = 1'b0;
        run_burst(1, 3, 2, 32'h100, 100, -1, 0);
        run_burst(2, 3, 2, 32'h108, 100, -1, 0);
        run_burst(0, 2, 2, 32'h40, 100, -1, 0);
        run_burst(1, 3, 2, 32'h100, 60, -1, 3);
        run_burst(1, 3, 2, 32'h100, 100, 1, 0);
        run_burst(1, 3, 2, 32'hFFFF_FFF8, 100, -1, 1);
        run_burst(2, 2, 2, 32'h100, 100, -1, 0);
        run_burst(1, 2, 3, 32'h13, 100, -1, 0);
        run_burst(2, 7, 0, 32'h35, 100, 7, 0);
        reset_mid_burst();
        run_burst(1, 0, 2, 32'h20, 100, -1, 0);
        for (int n = 0; n < 80; n++) begin
            bt  = $urandom_range(0, 2);
            len = (bt == 2 && $urandom_range(3) != 0) ? (2 << $urandom_range(3)) - 1 : $urandom_range(15);
            run_burst(bt, len, $urandom_range(0, 3),
                      $urandom_range(3) == 0 ? 32'hFFFF_FFE0 + $urandom_range(31) : $urandom,
                      $urandom_range(50, 100), $urandom_range(0, len + 3), $urandom_range(0, 3));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
